// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free registered outputs.
// Each channel latches its ratio/enable only at period boundaries and emits a period-start tick.
module clk_div_multi #(
  parameter int NUM_CH      = 2,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                          i_ref_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_tick
);

  localparam int W = RATIO_WIDTH;
  localparam logic [W:0] RATIO_MIN = (W+1)'(2);
  localparam logic [W:0] ONE_WIDE  = (W+1)'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] act_ratio;
    logic         act_en;
    logic         div_q;
    logic         tick_q;

    logic [W-1:0] ratio_in;
    logic         divided;
    logic         load;
    logic [W-1:0] cnt_next;
    logic [W-1:0] ratio_next;
    logic         en_next;
    logic         divided_next;
    logic [W:0]   half_next;

    assign ratio_in = i_div_ratio[c*W +: W];
    assign divided  = act_en & ({1'b0, act_ratio} >= RATIO_MIN);

    // A bypassed channel re-samples every cycle; a dividing one only at its last count.
    assign load = ~divided | (cnt == act_ratio - W'(1));

    always_comb begin
      cnt_next   = cnt + W'(1);
      ratio_next = act_ratio;
      en_next    = act_en;
      if (load) begin
        cnt_next   = '0;
        ratio_next = ratio_in;
        en_next    = i_clk_en[c];
      end
      divided_next = en_next & ({1'b0, ratio_next} >= RATIO_MIN);
      half_next    = ({1'b0, ratio_next} + ONE_WIDE) >> 1;
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
        cnt       <= '0;
        act_ratio <= '0;
        act_en    <= 1'b0;
        div_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt       <= cnt_next;
        act_ratio <= ratio_next;
        act_en    <= en_next;
        div_q     <= divided_next & ({1'b0, cnt_next} < half_next);
        tick_q    <= divided_next & (cnt_next == '0);
      end
    end

    // Only the bypass mux sits after the registers; it switches only when divided changes at a load.
    assign o_div_clk[c] = divided ? div_q : i_ref_clk;
    assign o_tick[c]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random ratio/enable traffic,
// checked against a period-level model of each channel.
module tb_clk_div_multi;

  localparam int NUM_CH = 2;
  localparam int RW     = 8;

  logic                 i_ref_clk = 1'b0;
  logic                 i_rst     = 1'b0;
  logic [NUM_CH-1:0]    i_clk_en  = '0;
  logic [NUM_CH*RW-1:0] i_div_ratio = '0;
  logic [NUM_CH-1:0]    o_div_clk;
  logic [NUM_CH-1:0]    o_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: length of the divided period in progress (0 = bypass) and position within it.
  int m_len [NUM_CH];
  int m_pos [NUM_CH];
  int hi_cnt;
  int tick_cnt;

  clk_div_multi #(.NUM_CH(NUM_CH), .RATIO_WIDTH(RW)) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst      (i_rst),
    .i_clk_en   (i_clk_en),
    .i_div_ratio(i_div_ratio),
    .o_div_clk  (o_div_clk),
    .o_tick     (o_tick)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [7:0] r0, input logic [7:0] r1);
    i_clk_en    = en;
    i_div_ratio = {r1, r0};
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_len[c] = 0;
      m_pos[c] = 0;
    end
  endtask

  // A new period starts when none is running or the running one has used up its length.
  task automatic modelClock();
    int r;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_len[c] == 0 || m_pos[c] == m_len[c] - 1) begin
        r = int'(i_div_ratio[c*RW +: RW]);
        m_len[c] = (i_clk_en[c] && r >= 2) ? r : 0;
        m_pos[c] = 0;
      end else begin
        m_pos[c]++;
      end
    end
  endtask

  task automatic checkAll(input string phase);
    logic exp_clk;
    logic exp_tick;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_len[c] != 0) exp_clk = (m_pos[c] < (m_len[c] + 1) / 2);
      else               exp_clk = i_ref_clk;
      exp_tick = (m_len[c] != 0) && (m_pos[c] == 0);
      checkOutput($sformatf("%s div_clk ch%0d", phase, c), 32'(o_div_clk[c]), 32'(exp_clk));
      checkOutput($sformatf("%s tick ch%0d", phase, c), 32'(o_tick[c]), 32'(exp_tick));
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_ref_clk);
      if (i_rst) modelClock();
      #1;
      checkAll("pos");
      if (o_div_clk[0]) hi_cnt++;
      if (o_tick[0])    tick_cnt++;
      @(negedge i_ref_clk);
      #1;
      checkAll("neg");
    end
  endtask

  task automatic waitPos(input int len, input int pos);
    int guard;
    guard = 0;
    while (!(m_len[0] == len && m_pos[0] == pos) && guard < 40) begin
      step(1);
      guard++;
    end
    checkOutput("reached ch0 position", 32'(guard < 40), 32'd1);
  endtask

  initial begin
    modelReset();
    step(3);

    // R=4 on ch0 straight out of reset
    applyStimulus(2'b01, 8'd4, 8'd0);
    i_rst = 1'b1;
    step(12);

    // R=5 then the ratio switch 4 -> 6 at count 1
    applyStimulus(2'b01, 8'd5, 8'd0);
    step(20);
    applyStimulus(2'b01, 8'd4, 8'd0);
    waitPos(4, 1);
    applyStimulus(2'b01, 8'd6, 8'd0);
    step(20);

    // disable at count 2 of a 6-cycle period, then re-enable
    waitPos(6, 2);
    applyStimulus(2'b00, 8'd6, 8'd0);
    step(12);
    applyStimulus(2'b01, 8'd6, 8'd0);
    step(10);

    // degenerate ratios stay in bypass, then R=3
    applyStimulus(2'b01, 8'd1, 8'd0);
    step(8);
    applyStimulus(2'b01, 8'd0, 8'd0);
    step(5);
    applyStimulus(2'b01, 8'd3, 8'd0);
    step(10);

    // maximum ratio: one full period has 128 high cycles and a single tick
    applyStimulus(2'b01, 8'd0, 8'd0);
    step(4);
    applyStimulus(2'b01, 8'd255, 8'd0);
    hi_cnt   = 0;
    tick_cnt = 0;
    step(255);
    checkOutput("max ratio high cycles", 32'(hi_cnt), 32'd128);
    checkOutput("max ratio ticks", 32'(tick_cnt), 32'd1);
    step(20);

    // both channels running, then an asynchronous reset mid-period
    applyStimulus(2'b11, 8'd4, 8'd3);
    step(9);
    i_rst = 1'b0;
    #1;
    modelReset();
    checkAll("rst");
    step(2);
    i_rst = 1'b1;
    step(15);

    // random traffic on both channels
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        automatic int c = $urandom_range(0, NUM_CH - 1);
        if ($urandom_range(0, 2) == 0) i_clk_en[c] = ~i_clk_en[c];
        else i_div_ratio[c*RW +: RW] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                                     : 8'($urandom_range(0, 12));
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider; successor to the single-channel divider.
- Each of NUM_CH channels divides i_ref_clk by its own ratio and drives a registered, glitch-free divided clock.
- Ratio and enable changes are taken only at period boundaries, so no runt pulses occur.
- Adds a per-channel period-start tick for synchronous consumers (UART prescalers, baud generators) in the clock-generation block.

Parameters:
- NUM_CH, 2, number of independent divider channels (>=1).
- RATIO_WIDTH, 8, bits per channel ratio; maximum ratio 2^RATIO_WIDTH-1.

Ports:
- i_ref_clk  input  1  reference clock; all state on posedge.
- i_rst  input  1  asynchronous, active-low reset.
- i_clk_en  input  NUM_CH  per-channel enable request; bit c belongs to channel c.
- i_div_ratio  input  NUM_CH*RATIO_WIDTH  packed ratios; channel c occupies bits [c*RATIO_WIDTH +: RATIO_WIDTH].
- o_div_clk  output  NUM_CH  per-channel output clock.
- o_tick  output  NUM_CH  registered 1-cycle pulse marking the first ref cycle of each divided period.

Behaviour:
- Reset is asynchronous and active-low; one clock only.
- Per-channel state: cnt (RATIO_WIDTH), act_ratio (RATIO_WIDTH, shadow), act_en, div_q, tick_q.
- Reset values: all state 0. o_tick=0. o_div_clk=i_ref_clk (bypass, because act_en=0).
- Definitions:
  - divided = act_en & (act_ratio >= 2).
  - half = (act_ratio+1)>>1, computed at RATIO_WIDTH+1 bits, i.e. ceil(R/2).
- Sample point (load): the shadow registers take act_en<=i_clk_en[c] and act_ratio<=i_div_ratio slice, and cnt<=0, when any of these holds:
  - channel not divided; sampled every cycle;
  - divided and cnt==act_ratio-1 (period end).
- Otherwise cnt<=cnt+1; act_en and act_ratio hold.
- Mid-period changes on i_clk_en or i_div_ratio are ignored until the period end. The period in progress always completes with its original ratio.
- div_q is registered from next-state values: div_q <= divided_next & (cnt_next < half_next).
  - High for the first ceil(R/2) ref cycles, low for the remaining floor(R/2).
  - Even R gives 50% duty; odd R is high-biased.
- tick_q <= divided_next & (cnt_next==0). o_tick=tick_q.
- o_div_clk[c] = divided ? div_q : i_ref_clk.
  - The bypass mux is the only combinational path on the output.
  - Switching between bypass and divided occurs only at a sample point.
- Latency: enable or ratio sampled at edge k gives o_div_clk rising and o_tick=1 at edge k, if the loaded ratio is >=2.
- Ratio 0 or 1 while enabled: bypass; o_tick stays 0; the input is re-sampled every cycle.
- Disable request: the current period finishes, then the channel enters bypass at the boundary edge. o_tick does not pulse on that edge.
- Simultaneous ratio change and disable at the boundary: disable wins (act_en=0); the new ratio is loaded but unused.
- Reset asserted mid-period: immediate bypass, all state cleared. After release the channel re-samples on the first posedge.
- Channels are fully independent; no shared counters.
- cnt never exceeds act_ratio-1. There is no wrap beyond the ratio, so there is no overflow at maximum ratio.

Test Plan:
- Ch0 en=1, R=4 from reset → o_div_clk pattern 1,1,0,0 repeating (period 4). o_tick high on every 4th cycle, aligned with each rising edge.
- Ch0 R=5 → high 3 cycles, low 2. o_tick every 5 cycles. Max ratio R=255 (RATIO_WIDTH=8) → high 128, low 127, no counter wrap.
- Running R=4; switch i_div_ratio to 6 at cnt=1 → current period completes as 4 cycles, then 3-high/3-low periods. No pulse shorter than 2 cycles.
- Running R=6; drop i_clk_en at cnt=2 → 6-cycle period completes, then o_div_clk follows i_ref_clk. o_tick stays 0 afterwards. Raising en again yields an immediate rising edge and o_tick.
- R=1 and R=0 with en=1 → o_div_clk equals i_ref_clk, o_tick=0. Changing to R=3 → divided output starts the next cycle, pattern 1,1,0.
- Ch0 R=4, ch1 R=3 concurrently. Assert i_rst low mid-period → both outputs bypass and o_tick=0 immediately. After release, both restart at cnt=0 with independent, correct periods.
